// File: rtl/mode_switch_sequencer_pkg.sv
// Shared definitions for the video mode-change sequencer: mode codes, the
// fallback mode used out of reset, sequencer state encodings and a helper
// that sizes the shared cycle timer.
package mode_switch_sequencer_pkg;

    // Video mode codes carried on config_data / active_mode
    localparam logic [7:0] MODE_VGA   = 8'h00;
    localparam logic [7:0] MODE_480p  = 8'h01;
    localparam logic [7:0] MODE_720p  = 8'h02;
    localparam logic [7:0] MODE_1080p = 8'h03;

    // Mode committed out of reset, before any selection has been made
    localparam logic [7:0] DEFAULT_FB_MODE = MODE_VGA;

    // Saturation limit of the lock-timeout retry counter
    localparam logic [3:0] RETRY_MAX = 4'd15;

    typedef enum logic [2:0] {
        MSEQ_RUN       = 3'd0,
        MSEQ_SETTLE    = 3'd1,
        MSEQ_BLANK     = 3'd2,
        MSEQ_PLL_RST   = 3'd3,
        MSEQ_WAIT_LOCK = 3'd4
    } mseq_state_t;

    // Timer holds N-1 for the longest interval, so clog2 of that interval
    // is enough; never narrower than one bit.
    function automatic int unsigned timer_width(input int unsigned max_cycles);
        int unsigned w;
        w = int'($clog2(max_cycles));
        return (w < 1) ? 1 : w;
    endfunction

    function automatic int unsigned max2(input int unsigned a, input int unsigned b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/mode_switch_sequencer_cycle_timer.sv
// cycle_timer: loadable down-counter shared by all timed sequencer states.
// Loading N-1 on state entry makes expired assert in the N-th cycle.
module cycle_timer
    import mode_switch_sequencer_pkg::*;
#(
    parameter int unsigned     WIDTH       = 8,
    parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             load,
    input  logic [WIDTH-1:0] load_value,
    output logic [WIDTH-1:0] value,
    output logic             expired
);

    logic [WIDTH-1:0] r_value;

    // Count down to zero and hold there until the next load
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_value <= RESET_VALUE;
        end else if (load) begin
            r_value <= load_value;
        end else if (r_value != '0) begin
            r_value <= r_value - 1'b1;
        end
    end

    assign value   = r_value;
    assign expired = (r_value == '0);

endmodule

// File: rtl/mode_switch_sequencer.sv
// mode_switch_sequencer: qualifies a newly selected video mode, blanks video,
// pulses the pixel PLL reset, waits for lock, then commits the mode and
// re-enables video.
// Optional feature: define MODE_SEQ_LOCK_TIMEOUT_EN to retry the PLL reset
// when lock is not reached within LOCK_TIMEOUT cycles (retry_count then
// counts timeouts, saturating at 15; otherwise it is tied to 0).
module mode_switch_sequencer
    import mode_switch_sequencer_pkg::*;
#(
    parameter int unsigned SETTLE_CYCLES  = 1024,
    parameter int unsigned BLANK_CYCLES   = 256,
    parameter int unsigned PLL_RST_CYCLES = 64,
    parameter int unsigned LOCK_TIMEOUT   = 65536
) (
    input  logic       clock,
    input  logic       reset,
    input  logic [7:0] config_data,
    input  logic       config_changed,
    input  logic       pll_locked,
    output logic [7:0] active_mode,
    output logic       pll_reset,
    output logic       video_enable,
    output logic       mode_busy,
    output logic       reconfig_strobe,
    output logic [3:0] retry_count
);

    localparam int unsigned MAX_CYCLES = max2(max2(SETTLE_CYCLES, BLANK_CYCLES),
                                              max2(PLL_RST_CYCLES, LOCK_TIMEOUT));
    localparam int unsigned TW = timer_width(MAX_CYCLES);

    localparam logic [TW-1:0] SETTLE_LOAD  = TW'(SETTLE_CYCLES - 1);
    localparam logic [TW-1:0] BLANK_LOAD   = TW'(BLANK_CYCLES - 1);
    localparam logic [TW-1:0] PLL_RST_LOAD = TW'(PLL_RST_CYCLES - 1);
`ifdef MODE_SEQ_LOCK_TIMEOUT_EN
    localparam logic [TW-1:0] LOCK_LOAD    = TW'(LOCK_TIMEOUT - 1);
`endif

    mseq_state_t r_state;
    logic [7:0]  r_active_mode;
    logic [7:0]  r_candidate;
    logic        r_pending;
    logic        r_pll_reset;
    logic        r_video_enable;
    logic        r_mode_busy;
    logic        r_reconfig_strobe;
    logic        r_lock_meta;
    logic        r_lock_sync;
`ifdef MODE_SEQ_LOCK_TIMEOUT_EN
    logic [3:0]  r_retry_count;
`endif

    logic          w_timer_load;
    logic [TW-1:0] w_timer_load_value;
    logic          w_timer_expired;
    // Remaining count is available for debug probing; sequencing uses expiry only
    logic [TW-1:0] w_unused_timer_value;

    cycle_timer #(
        .WIDTH       (TW),
        .RESET_VALUE (PLL_RST_LOAD)
    ) u_cycle_timer (
        .clock      (clock),
        .reset      (reset),
        .load       (w_timer_load),
        .load_value (w_timer_load_value),
        .value      (w_unused_timer_value),
        .expired    (w_timer_expired)
    );

    // Two-flop lock synchroniser; held clear while the PLL is in reset so a
    // stale lock from before the reset pulse cannot release WAIT_LOCK early.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_lock_meta <= 1'b0;
            r_lock_sync <= 1'b0;
        end else if (r_pll_reset) begin
            r_lock_meta <= 1'b0;
            r_lock_sync <= 1'b0;
        end else begin
            r_lock_meta <= pll_locked;
            r_lock_sync <= r_lock_meta;
        end
    end

    // Reload the timer on every transition into a timed state (and on a
    // re-qualifying config_changed during SETTLE)
    always_comb begin
        w_timer_load       = 1'b0;
        w_timer_load_value = '0;
        case (r_state)
            MSEQ_RUN: begin
                if (r_pending || config_changed) begin
                    w_timer_load       = 1'b1;
                    w_timer_load_value = SETTLE_LOAD;
                end
            end
            MSEQ_SETTLE: begin
                if (config_changed) begin
                    w_timer_load       = 1'b1;
                    w_timer_load_value = SETTLE_LOAD;
                end else if (w_timer_expired && (r_candidate != r_active_mode)) begin
                    w_timer_load       = 1'b1;
                    w_timer_load_value = BLANK_LOAD;
                end
            end
            MSEQ_BLANK: begin
                if (w_timer_expired) begin
                    w_timer_load       = 1'b1;
                    w_timer_load_value = PLL_RST_LOAD;
                end
            end
            MSEQ_PLL_RST: begin
`ifdef MODE_SEQ_LOCK_TIMEOUT_EN
                if (w_timer_expired) begin
                    w_timer_load       = 1'b1;
                    w_timer_load_value = LOCK_LOAD;
                end
`endif
            end
            MSEQ_WAIT_LOCK: begin
`ifdef MODE_SEQ_LOCK_TIMEOUT_EN
                if (!r_lock_sync && w_timer_expired) begin
                    w_timer_load       = 1'b1;
                    w_timer_load_value = PLL_RST_LOAD;
                end
`endif
            end
            default: begin
                w_timer_load       = 1'b1;
                w_timer_load_value = PLL_RST_LOAD;
            end
        endcase
    end

    // Sequencer FSM with all outputs registered on the transitions
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state           <= MSEQ_PLL_RST;
            r_active_mode     <= DEFAULT_FB_MODE;
            r_candidate       <= DEFAULT_FB_MODE;
            r_pending         <= 1'b0;
            r_pll_reset       <= 1'b1;
            r_video_enable    <= 1'b0;
            r_mode_busy       <= 1'b1;
            r_reconfig_strobe <= 1'b0;
`ifdef MODE_SEQ_LOCK_TIMEOUT_EN
            r_retry_count     <= 4'd0;
`endif
        end else begin
            r_reconfig_strobe <= 1'b0;
            case (r_state)
                MSEQ_RUN: begin
                    if (r_pending || config_changed) begin
                        if (config_changed) begin
                            r_candidate <= config_data;
                        end
                        r_pending   <= 1'b0;
                        r_mode_busy <= 1'b1;
                        r_state     <= MSEQ_SETTLE;
                    end
                end
                MSEQ_SETTLE: begin
                    if (config_changed) begin
                        r_candidate <= config_data;
                    end else if (w_timer_expired) begin
                        if (r_candidate == r_active_mode) begin
                            // Same mode re-selected: nothing to reconfigure
                            r_mode_busy <= 1'b0;
                            r_state     <= MSEQ_RUN;
                        end else begin
                            r_video_enable <= 1'b0;
                            r_state        <= MSEQ_BLANK;
                        end
                    end
                end
                MSEQ_BLANK: begin
                    if (config_changed) begin
                        r_candidate <= config_data;
                        r_pending   <= 1'b1;
                    end
                    if (w_timer_expired) begin
                        r_active_mode <= r_candidate;
                        r_pll_reset   <= 1'b1;
                        r_state       <= MSEQ_PLL_RST;
                    end
                end
                MSEQ_PLL_RST: begin
                    if (config_changed) begin
                        r_candidate <= config_data;
                        r_pending   <= 1'b1;
                    end
                    if (w_timer_expired) begin
                        r_pll_reset <= 1'b0;
                        r_state     <= MSEQ_WAIT_LOCK;
                    end
                end
                MSEQ_WAIT_LOCK: begin
                    if (config_changed) begin
                        r_candidate <= config_data;
                        r_pending   <= 1'b1;
                    end
                    if (r_lock_sync) begin
                        r_video_enable    <= 1'b1;
                        r_mode_busy       <= 1'b0;
                        r_reconfig_strobe <= 1'b1;
                        r_state           <= MSEQ_RUN;
`ifdef MODE_SEQ_LOCK_TIMEOUT_EN
                    end else if (w_timer_expired) begin
                        r_pll_reset <= 1'b1;
                        r_state     <= MSEQ_PLL_RST;
                        if (r_retry_count != RETRY_MAX) begin
                            r_retry_count <= r_retry_count + 4'd1;
                        end
`endif
                    end
                end
                default: begin
                    r_pll_reset    <= 1'b1;
                    r_video_enable <= 1'b0;
                    r_mode_busy    <= 1'b1;
                    r_state        <= MSEQ_PLL_RST;
                end
            endcase
        end
    end

    assign active_mode     = r_active_mode;
    assign pll_reset       = r_pll_reset;
    assign video_enable    = r_video_enable;
    assign mode_busy       = r_mode_busy;
    assign reconfig_strobe = r_reconfig_strobe;
`ifdef MODE_SEQ_LOCK_TIMEOUT_EN
    assign retry_count     = r_retry_count;
`else
    assign retry_count     = 4'd0;
`endif

endmodule

// File: tb/tb_mode_switch_sequencer.sv
// Bench for mode_switch_sequencer. Expected output snapshots are queued with
// the cycle they are due in when stimulus is applied, and compared on the
// falling edge of that cycle. Builds with or without MODE_SEQ_LOCK_TIMEOUT_EN.
module tb_mode_switch_sequencer;
    import mode_switch_sequencer_pkg::*;

    localparam int SC = 1024;
    localparam int BC = 256;
    localparam int PC = 64;
    localparam int LT = 100;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic [7:0] config_data = 8'h00;
    logic       config_changed = 1'b0;
    logic       pll_locked = 1'b1;
    logic [7:0] active_mode;
    logic       pll_reset;
    logic       video_enable;
    logic       mode_busy;
    logic       reconfig_strobe;
    logic [3:0] retry_count;

    mode_switch_sequencer #(
        .SETTLE_CYCLES  (SC),
        .BLANK_CYCLES   (BC),
        .PLL_RST_CYCLES (PC),
        .LOCK_TIMEOUT   (LT)
    ) dut (
        .clock           (clock),
        .reset           (reset),
        .config_data     (config_data),
        .config_changed  (config_changed),
        .pll_locked      (pll_locked),
        .active_mode     (active_mode),
        .pll_reset       (pll_reset),
        .video_enable    (video_enable),
        .mode_busy       (mode_busy),
        .reconfig_strobe (reconfig_strobe),
        .retry_count     (retry_count)
    );

    always #5 clock = ~clock;

    int cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    typedef struct {
        int         cyc;
        logic [7:0] mode;
        logic       ven;
        logic       prst;
        logic       busy;
        logic       stb;
        logic [3:0] retry;
        string      name;
    } exp_t;

    typedef struct {
        logic [7:0] cfg;
        int         lock_delay;
        bit         exp_commit;
        logic [7:0] exp_mode;
    } vec_t;

    exp_t exp_q[$];
    vec_t vecs[4];

    int total = 0;
    int bad = 0;
    int viol_cnt = 0;
    int strobe_cnt = 0;
    int exp_strobes = 0;
    bit win_en = 1'b0;
    bit done = 1'b0;

    logic [7:0] cur;
    int t, t2, b, p, k, r2, r3;

    function automatic void push(input int c, input logic [7:0] m, input logic ven,
                                 input logic prst, input logic busy, input logic stb,
                                 input logic [3:0] rt, input string nm);
        exp_t e;
        int   i;
        e.cyc = c; e.mode = m; e.ven = ven; e.prst = prst;
        e.busy = busy; e.stb = stb; e.retry = rt; e.name = nm;
        i = exp_q.size();
        while (i > 0 && exp_q[i-1].cyc > c) i--;
        exp_q.insert(i, e);
    endfunction

    // Scoreboard: compare every snapshot due in this cycle
    always @(negedge clock) begin
        exp_t e;
        while (exp_q.size() > 0 && exp_q[0].cyc <= cyc) begin
            e = exp_q.pop_front();
            total++;
            if (e.cyc != cyc || active_mode !== e.mode || video_enable !== e.ven ||
                pll_reset !== e.prst || mode_busy !== e.busy ||
                reconfig_strobe !== e.stb || retry_count !== e.retry) begin
                bad++;
                $display("FAIL %s @%0d: got mode=%h ven=%b prst=%b busy=%b stb=%b retry=%0d; want @%0d mode=%h ven=%b prst=%b busy=%b stb=%b retry=%0d",
                         e.name, cyc, active_mode, video_enable, pll_reset, mode_busy,
                         reconfig_strobe, retry_count, e.cyc, e.mode, e.ven, e.prst,
                         e.busy, e.stb, e.retry);
            end
        end
        if (done) begin
            total++;
            if (viol_cnt != 0) begin
                bad++;
                $display("FAIL same_mode_no_blank: got %0d disturbed cycles, want 0", viol_cnt);
            end
            total++;
            if (strobe_cnt != exp_strobes) begin
                bad++;
                $display("FAIL strobe_count: got %0d, want %0d", strobe_cnt, exp_strobes);
            end
            total++;
            if (exp_q.size() != 0) begin
                bad++;
                $display("FAIL unchecked_expectations: got %0d left, want 0", exp_q.size());
            end
            $display("test done: total=%0d bad=%0d", total, bad);
            $finish;
        end
    end

    // While a same-mode request is in flight, video must never be disturbed
    always @(negedge clock)
        if (win_en && (video_enable !== 1'b1 || pll_reset !== 1'b0 || reconfig_strobe !== 1'b0))
            viol_cnt <= viol_cnt + 1;

    always @(negedge clock)
        if (reconfig_strobe === 1'b1) strobe_cnt <= strobe_cnt + 1;

    task automatic goto(input int n);
        while (cyc < n) begin
            @(posedge clock);
            #1;
        end
    endtask

    task automatic pulse(input logic [7:0] m, input int at);
        goto(at);
        config_data = m;
        config_changed = 1'b1;
        goto(at + 1);
        config_changed = 1'b0;
    endtask

    // Expected blank -> PLL reset -> lock -> strobe tail; lock must be low on entry
    task automatic tail(input int bs, input logic [7:0] old_m, input logic [7:0] new_m, input int d);
        int pw;
        pw = bs + BC + PC;
        push(bs,          old_m, 0, 0, 1, 0, 4'd0, "blank_start");
        push(bs + BC - 1, old_m, 0, 0, 1, 0, 4'd0, "blank_end");
        push(bs + BC,     new_m, 0, 1, 1, 0, 4'd0, "pll_rst_rise");
        push(pw - 1,      new_m, 0, 1, 1, 0, 4'd0, "pll_rst_last");
        push(pw,          new_m, 0, 0, 1, 0, 4'd0, "wait_lock");
        push(pw + d + 2,  new_m, 0, 0, 1, 0, 4'd0, "pre_strobe");
        push(pw + d + 3,  new_m, 1, 0, 0, 1, 4'd0, "strobe");
        push(pw + d + 4,  new_m, 1, 0, 0, 0, 4'd0, "post_strobe");
        exp_strobes++;
        goto(pw + d);
        pll_locked = 1'b1;
        goto(pw + d + 6);
    endtask

    initial begin
        vecs[0] = '{MODE_720p,  10, 1'b1, MODE_720p};
        vecs[1] = '{MODE_720p,   0, 1'b0, MODE_720p};
        vecs[2] = '{MODE_1080p,  0, 1'b1, MODE_1080p};
        vecs[3] = '{MODE_480p,   3, 1'b1, MODE_480p};

        // Reset release with lock tied high
        push(2,          DEFAULT_FB_MODE, 0, 1, 1, 0, 4'd0, "reset_state");
        push(3 + PC - 1, DEFAULT_FB_MODE, 0, 1, 1, 0, 4'd0, "init_pll_last");
        push(3 + PC,     DEFAULT_FB_MODE, 0, 0, 1, 0, 4'd0, "init_wait");
        push(3 + PC + 2, DEFAULT_FB_MODE, 0, 0, 1, 0, 4'd0, "init_pre_run");
        push(3 + PC + 3, DEFAULT_FB_MODE, 1, 0, 0, 1, 4'd0, "init_strobe");
        push(3 + PC + 4, DEFAULT_FB_MODE, 1, 0, 0, 0, 4'd0, "init_run");
        exp_strobes = 1;
        goto(3);
        reset = 1'b0;
        goto(3 + PC + 6);
        cur = DEFAULT_FB_MODE;

        // Table of single mode requests
        for (int i = 0; i < 4; i++) begin
            t = cyc;
            push(t,      cur, 1, 0, 0, 0, 4'd0, "run_idle");
            push(t + 1,  cur, 1, 0, 1, 0, 4'd0, "settle_start");
            push(t + SC, cur, 1, 0, 1, 0, 4'd0, "settle_end");
            if (vecs[i].exp_commit) begin
                pll_locked = 1'b0;
                pulse(vecs[i].cfg, t);
                tail(t + SC + 1, cur, vecs[i].exp_mode, vecs[i].lock_delay);
            end else begin
                win_en = 1'b1;
                push(t + SC + 1, cur, 1, 0, 0, 0, 4'd0, "same_mode_run");
                pulse(vecs[i].cfg, t);
                goto(t + SC + 3);
                win_en = 1'b0;
            end
            cur = vecs[i].exp_mode;
        end

        // Second request 500 cycles into SETTLE restarts qualification
        t = cyc;
        t2 = t + 500;
        pll_locked = 1'b0;
        push(t + 1,    cur, 1, 0, 1, 0, 4'd0, "dbl_settle");
        push(t + SC + 1, cur, 1, 0, 1, 0, 4'd0, "dbl_restarted");
        push(t2 + SC,  cur, 1, 0, 1, 0, 4'd0, "dbl_settle_end");
        pulse(MODE_720p, t);
        pulse(MODE_1080p, t2);
        tail(t2 + SC + 1, cur, MODE_1080p, 1);
        cur = MODE_1080p;

        // Request during WAIT_LOCK becomes pending and runs a second sequence
        t = cyc;
        pll_locked = 1'b0;
        b = t + SC + 1;
        p = b + BC + PC;
        push(b,                cur,       0, 0, 1, 0, 4'd0, "wl_blank");
        push(b + BC,           MODE_720p, 0, 1, 1, 0, 4'd0, "wl_pll_rst");
        push(p,                MODE_720p, 0, 0, 1, 0, 4'd0, "wl_wait");
        push(p + 23,           MODE_720p, 1, 0, 0, 1, 4'd0, "wl_strobe");
        push(p + 24,           MODE_720p, 1, 0, 1, 0, 4'd0, "wl_pending_settle");
        push(p + 24 + SC - 1,  MODE_720p, 1, 0, 1, 0, 4'd0, "wl_settle_end");
        exp_strobes++;
        pulse(MODE_720p, t);
        pulse(MODE_480p, p + 5);
        goto(p + 20);
        pll_locked = 1'b1;
        goto(p + 30);
        pll_locked = 1'b0;
        tail(p + 24 + SC, MODE_720p, MODE_480p, 7);
        cur = MODE_480p;

        // Asynchronous reset in WAIT_LOCK after a new mode was committed
        t = cyc;
        pll_locked = 1'b0;
        b = t + SC + 1;
        p = b + BC + PC;
        k = p + 5;
        r2 = k + 2;
        push(b + BC,       MODE_1080p,      0, 1, 1, 0, 4'd0, "rs_committed");
        push(k - 1,        MODE_1080p,      0, 0, 1, 0, 4'd0, "rs_wait");
        push(k,            DEFAULT_FB_MODE, 0, 1, 1, 0, 4'd0, "rs_async_reset");
        push(k + 1,        DEFAULT_FB_MODE, 0, 1, 1, 0, 4'd0, "rs_hold");
        push(r2 + PC - 1,  DEFAULT_FB_MODE, 0, 1, 1, 0, 4'd0, "rs_pll_last");
        push(r2 + PC,      DEFAULT_FB_MODE, 0, 0, 1, 0, 4'd0, "rs_wait2");
        push(r2 + PC + 3,  DEFAULT_FB_MODE, 1, 0, 0, 1, 4'd0, "rs_strobe");
        exp_strobes++;
        pulse(MODE_1080p, t);
        goto(k);
        pll_locked = 1'b1;
        reset = 1'b1;
        goto(r2);
        reset = 1'b0;
        goto(r2 + PC + 6);
        cur = DEFAULT_FB_MODE;

        // Lock never arrives after a reset
        t = cyc;
        r3 = t + 2;
        push(t + 1, DEFAULT_FB_MODE, 0, 1, 1, 0, 4'd0, "lk_reset");
`ifdef MODE_SEQ_LOCK_TIMEOUT_EN
        for (int n = 1; n <= 16; n++) begin
            push(r3 + n * (PC + LT) - 1, DEFAULT_FB_MODE, 0, 0, 1, 0,
                 4'((n - 1 > 15) ? 15 : n - 1), "to_wait_end");
            push(r3 + n * (PC + LT),     DEFAULT_FB_MODE, 0, 1, 1, 0,
                 4'((n > 15) ? 15 : n), "to_pll_rst");
        end
        push(r3 + 16 * (PC + LT) + 73, DEFAULT_FB_MODE, 1, 0, 0, 1, 4'd15, "to_strobe");
        exp_strobes++;
        reset = 1'b1;
        pll_locked = 1'b0;
        goto(r3);
        reset = 1'b0;
        goto(r3 + 16 * (PC + LT) + 70);
        pll_locked = 1'b1;
        goto(r3 + 16 * (PC + LT) + 76);
`else
        push(r3 + PC + 300, DEFAULT_FB_MODE, 0, 0, 1, 0, 4'd0, "no_timeout_wait");
        push(r3 + 402,      DEFAULT_FB_MODE, 0, 0, 1, 0, 4'd0, "late_pre_strobe");
        push(r3 + 403,      DEFAULT_FB_MODE, 1, 0, 0, 1, 4'd0, "late_strobe");
        exp_strobes++;
        reset = 1'b1;
        pll_locked = 1'b0;
        goto(r3);
        reset = 1'b0;
        goto(r3 + 400);
        pll_locked = 1'b1;
        goto(r3 + 406);
`endif

        goto(cyc + 3);
        done = 1'b1;
    end

endmodule
